// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: state encoding and frame-length rule.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [8:0] MAX_LEN            = 9'd256;
  localparam bit         LEN_ZERO_MEANS_MAX = 1'b1;

  // Number of data bytes announced by a length byte.
  function automatic logic [8:0] frame_len(input logic [7:0] len_byte);
    if (LEN_ZERO_MEANS_MAX && (len_byte == 8'd0)) begin
      return MAX_LEN;
    end
    return {1'b0, len_byte};
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Host byte stream, program memory write port and CPU status for the loader.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic [7:0]            inData;
  logic                  inValid;
  logic                  inReady;
  logic [ADDR_WIDTH-1:0] memWrAddr;
  logic [7:0]            memWrData;
  logic                  memWrEn;
  logic                  cpuRst;
  logic                  done;
  logic                  err;

  modport master (
    input  start, inData, inValid,
    output inReady, memWrAddr, memWrData, memWrEn, cpuRst, done, err
  );

  modport slave (
    output start, inData, inValid,
    input  inReady, memWrAddr, memWrData, memWrEn, cpuRst, done, err
  );
endinterface

// File: rtl/program_loader_xor_accumulator.sv
// 8-bit XOR accumulator holding the running frame checksum.
module xor_accumulator
  import loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic       acc,
  input  logic [7:0] din,
  output logic [7:0] value
);
  logic [7:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = 8'd0;
    end else if (load) begin
      value_d = din;
    end else if (acc) begin
      value_d = value_q ^ din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= 8'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
endmodule

// File: rtl/program_loader.sv
// Loads a length-framed, XOR-checksummed image into program memory while
// holding the CPU in reset; releases it only after the checksum verifies.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int START_ADDR = 0
) (
  input  logic             clk,
  input  logic             rst,
  program_loader_if.master bus
);
  localparam logic [ADDR_WIDTH-1:0] START_W = ADDR_WIDTH'(START_ADDR);

  state_e                state_q, state_d;
  logic [8:0]            remaining_q, remaining_d;
  logic [8:0]            index_q, index_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  in_ready_q, in_ready_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic       csum_clr, csum_load, csum_acc;
  logic [7:0] csum;
  logic       xfer;

  assign xfer = bus.inValid & in_ready_q;

  xor_accumulator u_csum (
    .clk   (clk),
    .rst   (rst),
    .clr   (csum_clr),
    .load  (csum_load),
    .acc   (csum_acc),
    .din   (bus.inData),
    .value (csum)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    index_d     = index_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wr_en_d     = 1'b0;
    cpu_rst_d   = cpu_rst_q;
    done_d      = done_q;
    err_d       = err_q;
    csum_clr    = 1'b0;
    csum_load   = 1'b0;
    csum_acc    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_LEN;
          cpu_rst_d = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          csum_clr  = 1'b1;
        end
      end
      ST_LEN: begin
        if (xfer) begin
          remaining_d = frame_len(bus.inData);
          index_d     = 9'd0;
          csum_load   = 1'b1;
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          csum_acc    = 1'b1;
          index_d     = index_q + 9'd1;
          remaining_d = remaining_q - 9'd1;
          // Address arithmetic wraps naturally at the top of memory.
          addr_d      = START_W + ADDR_WIDTH'(index_q);
          data_d      = bus.inData;
          wr_en_d     = 1'b1;
          if (remaining_q == 9'd1) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (xfer) begin
          if (bus.inData == csum) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d   = ST_IDLE;
            err_d     = 1'b1;
            cpu_rst_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          state_d   = ST_LEN;
          cpu_rst_d = 1'b1;
          done_d    = 1'b0;
          csum_clr  = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cpu_rst_d = 1'b1;
      end
    endcase

    in_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CHECK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= 9'd0;
      index_q     <= 9'd0;
      addr_q      <= '0;
      data_q      <= 8'd0;
      wr_en_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      index_q     <= index_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_en_q     <= wr_en_d;
      in_ready_q  <= in_ready_d;
      cpu_rst_q   <= cpu_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.inReady   = in_ready_q;
  assign bus.memWrAddr = addr_q;
  assign bus.memWrData = data_q;
  assign bus.memWrEn   = wr_en_q;
  assign bus.cpuRst    = cpu_rst_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule
